// File: rtl/mul_div_pkg.sv
// Shared opcode and FSM state definitions for the iterative multiply/divide unit
// and the control decode that drives it.
package mul_div_pkg;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_CALC = 2'b01,
        S_FIX  = 2'b10,
        S_DONE = 2'b11
    } state_t;

endpackage

// File: rtl/mul_div_if.sv
// Datapath-side bundle of the multiply/divide unit: launch, MTHI/MTLO writes,
// status and the HI/LO read ports.
interface mul_div_if #(
    parameter int WIDTH = 32
);
    logic             start_i;
    logic [1:0]       op_i;
    logic [WIDTH-1:0] data1_i;
    logic [WIDTH-1:0] data2_i;
    logic             hi_we_i;
    logic             lo_we_i;
    logic [WIDTH-1:0] wdata_i;
    logic             busy_o;
    logic             done_o;
    logic [WIDTH-1:0] hi_o;
    logic [WIDTH-1:0] lo_o;

    modport master (
        output start_i, op_i, data1_i, data2_i, hi_we_i, lo_we_i, wdata_i,
        input  busy_o, done_o, hi_o, lo_o
    );

    modport slave (
        input  start_i, op_i, data1_i, data2_i, hi_we_i, lo_we_i, wdata_i,
        output busy_o, done_o, hi_o, lo_o
    );
endinterface

// File: rtl/mul_div_step.sv
// One iteration of the unsigned datapath: a shift-add multiply step or a
// restoring divide step on the {acc_hi, acc_lo} accumulator.
module mul_div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] i_acc_hi,
    input  logic [WIDTH-1:0] i_acc_lo,
    input  logic [WIDTH-1:0] i_operand,
    input  logic             i_div,
    output logic [WIDTH-1:0] o_acc_hi,
    output logic [WIDTH-1:0] o_acc_lo
);

    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_shift;
    logic [WIDTH-1:0] w_sub;
    logic             w_ge;

    always_comb begin
        w_sum   = {1'b0, i_acc_hi} + (i_acc_lo[0] ? {1'b0, i_operand} : '0);
        w_shift = {i_acc_hi, i_acc_lo[WIDTH-1]};
        w_ge    = (w_shift >= {1'b0, i_operand});
        // A successful subtract always lands below the divisor, so WIDTH bits suffice.
        w_sub   = w_shift[WIDTH-1:0] - i_operand;
        if (i_div) begin
            o_acc_hi = w_ge ? w_sub : w_shift[WIDTH-1:0];
            o_acc_lo = {i_acc_lo[WIDTH-2:0], w_ge};
        end else begin
            o_acc_hi = w_sum[WIDTH:1];
            o_acc_lo = {w_sum[0], i_acc_lo[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/mul_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with HI/LO registers and fixed WIDTH+2 latency.
// Define MUL_DIV_SIGNED_EN for signed MULT/DIV; otherwise every op runs unsigned.
import mul_div_pkg::*;

module mul_div_unit #(
    parameter int WIDTH = 32
) (
    input logic    clk_i,
    input logic    rst_i,
    mul_div_if.slave bus
);

    localparam int CW = $clog2(WIDTH) + 1;

    state_t           r_state;
    state_t           w_next;
    logic [CW-1:0]    r_cnt;
    logic             r_div;
    logic             r_neg1;
    logic             r_neg2;
    logic             r_div0;
    logic [WIDTH-1:0] r_acc_hi;
    logic [WIDTH-1:0] r_acc_lo;
    logic [WIDTH-1:0] r_opnd;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;

    logic             w_signed;
    logic             w_is_div;
    logic             w_neg1;
    logic             w_neg2;
    logic [WIDTH-1:0] w_mag1;
    logic [WIDTH-1:0] w_mag2;
    logic [WIDTH-1:0] w_step_hi;
    logic [WIDTH-1:0] w_step_lo;
    logic [2*WIDTH-1:0] w_prod;
    logic [2*WIDTH-1:0] w_prod_fix;
    logic [WIDTH-1:0] w_fix_hi;
    logic [WIDTH-1:0] w_fix_lo;

`ifdef MUL_DIV_SIGNED_EN
    assign w_signed = (bus.op_i == OP_MULT) || (bus.op_i == OP_DIV);
`else
    assign w_signed = 1'b0;
`endif

    always_comb begin
        w_is_div = (bus.op_i == OP_DIV) || (bus.op_i == OP_DIVU);
        w_neg1   = w_signed & bus.data1_i[WIDTH-1];
        w_neg2   = w_signed & bus.data2_i[WIDTH-1];
        w_mag1   = w_neg1 ? (~bus.data1_i + 1'b1) : bus.data1_i;
        w_mag2   = w_neg2 ? (~bus.data2_i + 1'b1) : bus.data2_i;
    end

    mul_div_step #(.WIDTH(WIDTH)) u_step (
        .i_acc_hi  (r_acc_hi),
        .i_acc_lo  (r_acc_lo),
        .i_operand (r_opnd),
        .i_div     (r_div),
        .o_acc_hi  (w_step_hi),
        .o_acc_lo  (w_step_lo)
    );

    // Divide by zero keeps the all-ones quotient; the remainder still takes the
    // dividend sign, which restores the original dividend.
    always_comb begin
        w_prod     = {r_acc_hi, r_acc_lo};
        w_prod_fix = (r_neg1 ^ r_neg2) ? (~w_prod + 1'b1) : w_prod;
        if (r_div) begin
            w_fix_lo = ((r_neg1 ^ r_neg2) && !r_div0) ? (~r_acc_lo + 1'b1) : r_acc_lo;
            w_fix_hi = r_neg1 ? (~r_acc_hi + 1'b1) : r_acc_hi;
        end else begin
            w_fix_hi = w_prod_fix[2*WIDTH-1:WIDTH];
            w_fix_lo = w_prod_fix[WIDTH-1:0];
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (bus.start_i) w_next = S_CALC;
            S_CALC:  if (r_cnt == CW'(1)) w_next = S_FIX;
            S_FIX:   w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_cnt    <= '0;
            r_div    <= 1'b0;
            r_neg1   <= 1'b0;
            r_neg2   <= 1'b0;
            r_div0   <= 1'b0;
            r_acc_hi <= '0;
            r_acc_lo <= '0;
            r_opnd   <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.start_i) begin
                        r_cnt    <= CW'(WIDTH);
                        r_div    <= w_is_div;
                        r_neg1   <= w_neg1;
                        r_neg2   <= w_neg2;
                        r_div0   <= (bus.data2_i == '0);
                        r_acc_hi <= '0;
                        r_acc_lo <= w_is_div ? w_mag1 : w_mag2;
                        r_opnd   <= w_is_div ? w_mag2 : w_mag1;
                    end else begin
                        if (bus.hi_we_i) r_hi <= bus.wdata_i;
                        if (bus.lo_we_i) r_lo <= bus.wdata_i;
                    end
                end
                S_CALC: begin
                    r_acc_hi <= w_step_hi;
                    r_acc_lo <= w_step_lo;
                    r_cnt    <= r_cnt - 1'b1;
                end
                S_FIX: begin
                    r_hi <= w_fix_hi;
                    r_lo <= w_fix_lo;
                end
                default: ;
            endcase
        end
    end

    assign bus.busy_o = (r_state == S_CALC) || (r_state == S_FIX);
    assign bus.done_o = (r_state == S_DONE);
    assign bus.hi_o   = r_hi;
    assign bus.lo_o   = r_lo;

endmodule

// File: tb/tb_mul_div_unit.sv
// Scoreboard bench for mul_div_unit: expected HI/LO are queued at launch and
// compared when done_o pulses; expectations follow MUL_DIV_SIGNED_EN.
module tb_mul_div_unit;
    import mul_div_pkg::*;

    localparam int W = 32;

    typedef struct {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
    } exp_t;

    logic clk;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    mul_div_if #(.WIDTH(W)) bus ();

    mul_div_unit #(.WIDTH(W)) dut (
        .clk_i (clk),
        .rst_i (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [2*W-1:0] model(input logic [1:0] op, input logic [W-1:0] a,
                                            input logic [W-1:0] b);
        logic             sgn;
        logic [2*W-1:0]   ax, bx;
        logic signed [W-1:0] da, db;
        logic [W-1:0]     q, r;
`ifdef MUL_DIV_SIGNED_EN
        sgn = !op[0];
`else
        sgn = 1'b0;
`endif
        if (!op[1]) begin
            ax = sgn ? {{W{a[W-1]}}, a} : {{W{1'b0}}, a};
            bx = sgn ? {{W{b[W-1]}}, b} : {{W{1'b0}}, b};
            return ax * bx;
        end
        if (b == '0) return {a, {W{1'b1}}};
        if (sgn && a == {1'b1, {(W-1){1'b0}}} && b == {W{1'b1}})
            return {{W{1'b0}}, 1'b1, {(W-1){1'b0}}};
        if (sgn) begin
            da = a;
            db = b;
            q  = da / db;
            r  = da % db;
        end else begin
            q = a / b;
            r = a % b;
        end
        return {r, q};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        logic [2*W-1:0] m;
        int g;
        g = 0;
        while ((bus.busy_o === 1'b1 || bus.done_o === 1'b1) && g < 100) begin
            tick();
            g++;
        end
        m = model(op, a, b);
        sb.push_back('{hi: m[2*W-1:W], lo: m[W-1:0]});
        bus.op_i    = op;
        bus.data1_i = a;
        bus.data2_i = b;
        bus.start_i = 1'b1;
        tick();
        bus.start_i = 1'b0;
    endtask

    // Returns the cycle index at which done_o is seen; the launch cycle is index 0.
    task automatic wait_done(input int c0, output int cyc);
        cyc = c0;
        while (bus.done_o !== 1'b1 && cyc < 200) begin
            tick();
            cyc++;
        end
    endtask

    task automatic test_reset();
        checks++; if (bus.busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b exp 0", bus.busy_o); end
        checks++; if (bus.done_o !== 1'b0) begin errors++; $display("FAIL reset_done: got %b exp 0", bus.done_o); end
        checks++; if (bus.hi_o !== '0) begin errors++; $display("FAIL reset_hi: got %h exp 0", bus.hi_o); end
        checks++; if (bus.lo_o !== '0) begin errors++; $display("FAIL reset_lo: got %h exp 0", bus.lo_o); end
    endtask

    task automatic test_vectors();
        logic [1:0]   v_op [6] = '{OP_MULTU, OP_MULT, OP_DIV, OP_DIVU, OP_DIV, OP_MULT};
        logic [W-1:0] v_a  [6] = '{32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'hFFFF_FFF9, 32'd10,
                                   32'h8000_0000, 32'hFFFF_FFFF};
        logic [W-1:0] v_b  [6] = '{32'hFFFF_FFFF, 32'd5, 32'd2, 32'd0, 32'hFFFF_FFFF, 32'd2};
        exp_t e;
        int   cyc;
        for (int i = 0; i < 6; i++) begin
            issue(v_op[i], v_a[i], v_b[i]);
            wait_done(1, cyc);
            e = sb.pop_front();
            checks++; if (cyc != W + 2) begin errors++; $display("FAIL vec%0d_latency: got %0d exp %0d", i, cyc, W + 2); end
            checks++; if (bus.hi_o !== e.hi) begin errors++; $display("FAIL vec%0d_hi: got %h exp %h", i, bus.hi_o, e.hi); end
            checks++; if (bus.lo_o !== e.lo) begin errors++; $display("FAIL vec%0d_lo: got %h exp %h", i, bus.lo_o, e.lo); end
            tick();
            checks++; if (bus.done_o !== 1'b0) begin errors++; $display("FAIL vec%0d_done_pulse: got %b exp 0", i, bus.done_o); end
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        int   cyc;
        logic [1:0]   op;
        logic [W-1:0] a, b;
        for (int i = 0; i < 12; i++) begin
            op = 2'($urandom_range(0, 3));
            a  = $urandom;
            b  = (i % 3 == 2) ? W'($urandom_range(1, 7)) : W'($urandom);
            issue(op, a, b);
            wait_done(1, cyc);
            e = sb.pop_front();
            checks++; if (cyc != W + 2) begin errors++; $display("FAIL b2b%0d_latency: got %0d exp %0d", i, cyc, W + 2); end
            checks++; if (bus.hi_o !== e.hi) begin errors++; $display("FAIL b2b%0d_hi op=%0d a=%h b=%h: got %h exp %h", i, op, a, b, bus.hi_o, e.hi); end
            checks++; if (bus.lo_o !== e.lo) begin errors++; $display("FAIL b2b%0d_lo op=%0d a=%h b=%h: got %h exp %h", i, op, a, b, bus.lo_o, e.lo); end
        end
    endtask

    task automatic test_mid_op();
        exp_t         e;
        int           cyc, n;
        logic [W-1:0] old_hi;
        issue(OP_MULTU, 32'd6, 32'd7);
        old_hi = bus.hi_o;
        repeat (3) tick();
        bus.op_i    = OP_DIVU;
        bus.data1_i = 32'd9;
        bus.data2_i = 32'd3;
        bus.start_i = 1'b1;
        bus.hi_we_i = 1'b1;
        bus.wdata_i = 32'h55;
        tick();
        bus.start_i = 1'b0;
        bus.hi_we_i = 1'b0;
        checks++; if (bus.hi_o !== old_hi) begin errors++; $display("FAIL mid_hi_hold: got %h exp %h", bus.hi_o, old_hi); end
        checks++; if (bus.busy_o !== 1'b1) begin errors++; $display("FAIL mid_busy: got %b exp 1", bus.busy_o); end
        wait_done(5, cyc);
        e = sb.pop_front();
        checks++; if (cyc != W + 2) begin errors++; $display("FAIL mid_latency: got %0d exp %0d", cyc, W + 2); end
        checks++; if (bus.hi_o !== e.hi) begin errors++; $display("FAIL mid_hi: got %h exp %h", bus.hi_o, e.hi); end
        checks++; if (bus.lo_o !== 32'd42) begin errors++; $display("FAIL mid_lo: got %h exp %h", bus.lo_o, 32'd42); end
        n = 0;
        repeat (40) begin
            tick();
            if (bus.done_o === 1'b1) n++;
        end
        checks++; if (n != 0) begin errors++; $display("FAIL mid_no_queue: got %0d extra done exp 0", n); end
        bus.hi_we_i = 1'b1;
        bus.wdata_i = 32'h55;
        tick();
        bus.hi_we_i = 1'b0;
        checks++; if (bus.hi_o !== 32'h55) begin errors++; $display("FAIL mthi: got %h exp 00000055", bus.hi_o); end
        checks++; if (bus.lo_o !== 32'd42) begin errors++; $display("FAIL mthi_lo_keep: got %h exp 0000002a", bus.lo_o); end
        bus.hi_we_i = 1'b1;
        bus.lo_we_i = 1'b1;
        bus.wdata_i = 32'h1234;
        tick();
        bus.hi_we_i = 1'b0;
        bus.lo_we_i = 1'b0;
        checks++; if (bus.hi_o !== 32'h1234) begin errors++; $display("FAIL both_we_hi: got %h exp 00001234", bus.hi_o); end
        checks++; if (bus.lo_o !== 32'h1234) begin errors++; $display("FAIL both_we_lo: got %h exp 00001234", bus.lo_o); end
        bus.lo_we_i = 1'b1;
        bus.wdata_i = 32'hAA;
        issue(OP_MULTU, 32'd3, 32'd4);
        bus.lo_we_i = 1'b0;
        checks++; if (bus.lo_o !== 32'h1234) begin errors++; $display("FAIL start_wins: got %h exp 00001234", bus.lo_o); end
        wait_done(1, cyc);
        e = sb.pop_front();
        checks++; if (bus.lo_o !== e.lo) begin errors++; $display("FAIL start_wins_lo: got %h exp %h", bus.lo_o, e.lo); end
    endtask

    task automatic test_reset_mid();
        exp_t e;
        int   cyc;
        tick();
        bus.hi_we_i = 1'b1;
        bus.wdata_i = 32'hDEAD;
        tick();
        bus.hi_we_i = 1'b0;
        issue(OP_MULTU, 32'd5, 32'd5);
        repeat (8) tick();
        #3 rst_n = 1'b0;
        #1;
        checks++; if (bus.busy_o !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b exp 0", bus.busy_o); end
        checks++; if (bus.hi_o !== '0) begin errors++; $display("FAIL rstmid_hi: got %h exp 0", bus.hi_o); end
        checks++; if (bus.lo_o !== '0) begin errors++; $display("FAIL rstmid_lo: got %h exp 0", bus.lo_o); end
        sb.delete();
        @(posedge clk);
        #2 rst_n = 1'b1;
        tick();
        issue(OP_MULTU, 32'd2, 32'd3);
        wait_done(1, cyc);
        e = sb.pop_front();
        checks++; if (cyc != W + 2) begin errors++; $display("FAIL rstmid_latency: got %0d exp %0d", cyc, W + 2); end
        checks++; if (bus.lo_o !== 32'd6) begin errors++; $display("FAIL rstmid_lo6: got %h exp 00000006", bus.lo_o); end
        checks++; if (bus.hi_o !== e.hi) begin errors++; $display("FAIL rstmid_hi6: got %h exp %h", bus.hi_o, e.hi); end
    endtask

    initial begin
        rst_n       = 1'b0;
        bus.start_i = 1'b0;
        bus.op_i    = '0;
        bus.data1_i = '0;
        bus.data2_i = '0;
        bus.hi_we_i = 1'b0;
        bus.lo_we_i = 1'b0;
        bus.wdata_i = '0;
        #2;
        test_reset();
        #10 rst_n = 1'b1;
        tick();
        test_vectors();
        test_back_to_back();
        test_mid_op();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog expired");
    end

endmodule
